// File: rtl/axi_outstanding_gate.sv
// axi_outstanding_gate: caps outstanding AXI read/write bursts on the cache
// subsystem's master port and offers a quiesce/drain handshake. The payload
// passes straight through. Only AR/AW valid/ready are gated.

// Stand-in for the subsystem's AXI request/response structs.
package axi_gate_pkg;
    localparam int unsigned IdWidth   = 4;
    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 64;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
    } ax_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0]   data;
        logic [DataWidth/8-1:0] strb;
        logic                   last;
    } w_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [1:0]         resp;
    } b_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
        logic                 last;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;
endpackage

module axi_outstanding_gate #(
    parameter int unsigned AxiIdWidth   = 4,
    parameter int unsigned MaxReadTxns  = 8,
    parameter int unsigned MaxWriteTxns = 8,
    parameter type axi_req_t = axi_gate_pkg::req_t,
    parameter type axi_rsp_t = axi_gate_pkg::resp_t
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  axi_req_t                            slv_req_i,
    output axi_rsp_t                            slv_resp_o,
    output axi_req_t                            mst_req_o,
    input  axi_rsp_t                            mst_resp_i,
    input  logic                                quiesce_req_i,
    output logic                                quiesce_ack_o,
    output logic                                busy_o,
    output logic [$clog2(MaxReadTxns+1)-1:0]    rd_outstanding_o,
    output logic [$clog2(MaxWriteTxns+1)-1:0]   wr_outstanding_o,
    output logic                                err_o
);
    localparam int unsigned RdCntW = $clog2(MaxReadTxns + 1);
    localparam int unsigned WrCntW = $clog2(MaxWriteTxns + 1);
    localparam logic [RdCntW-1:0] RdMax = RdCntW'(MaxReadTxns);
    localparam logic [WrCntW-1:0] WrMax = WrCntW'(MaxWriteTxns);

    if (MaxReadTxns < 1 || MaxWriteTxns < 1 || $bits(slv_req_i.ar.id) != AxiIdWidth) begin : gen_bad_params
        $error("axi_outstanding_gate: limits must be >= 1 and ID width must match the request type");
    end

    typedef enum logic [1:0] {IDLE, DRAIN, HALTED} state_e;

    state_e              state_q, state_d;
    logic [RdCntW-1:0]   rd_cnt_q, rd_cnt_d;
    logic [WrCntW-1:0]   wr_cnt_q, wr_cnt_d;
    logic                ar_presented_q, ar_presented_d;
    logic                aw_presented_q, aw_presented_d;
    logic                err_q, err_d;

    logic quiesce_active;
    logic ar_allow, aw_allow;
    logic ar_hs, aw_hs, r_last_hs, b_hs;
    logic drained_d;

    // An AR/AW already shown downstream must stay valid until accepted, so the
    // presented flag overrides the block. Reset forces both directions shut.
    assign quiesce_active = (state_q != IDLE);
    assign ar_allow = ~rst_i & (ar_presented_q | ~(quiesce_active | (rd_cnt_q == RdMax)));
    assign aw_allow = ~rst_i & (aw_presented_q | ~(quiesce_active | (wr_cnt_q == WrMax)));

    // Passthrough of every channel with only the AR/AW handshake gated.
    always_comb begin
        // NOTE: every combinational output gets a full default first so no path leaves it unassigned (no latch).
        mst_req_o           = slv_req_i;
        mst_req_o.ar_valid  = slv_req_i.ar_valid & ar_allow;
        mst_req_o.aw_valid  = slv_req_i.aw_valid & aw_allow;
        slv_resp_o          = mst_resp_i;
        slv_resp_o.ar_ready = mst_resp_i.ar_ready & ar_allow;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready & aw_allow;
    end

    assign ar_hs     = mst_req_o.ar_valid & mst_resp_i.ar_ready;
    assign aw_hs     = mst_req_o.aw_valid & mst_resp_i.aw_ready;
    assign r_last_hs = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;
    assign b_hs      = mst_resp_i.b_valid & slv_req_i.b_ready;

    // Next counts, presented flags and the sticky underflow error.
    always_comb begin
        rd_cnt_d       = rd_cnt_q;
        wr_cnt_d       = wr_cnt_q;
        err_d          = err_q;
        ar_presented_d = ar_presented_q;
        aw_presented_d = aw_presented_q;

        if (ar_hs && !r_last_hs) begin
            rd_cnt_d = rd_cnt_q + RdCntW'(1);
        end else if (!ar_hs && r_last_hs) begin
            if (rd_cnt_q == '0) err_d = 1'b1;
            else                rd_cnt_d = rd_cnt_q - RdCntW'(1);
        end

        if (aw_hs && !b_hs) begin
            wr_cnt_d = wr_cnt_q + WrCntW'(1);
        end else if (!aw_hs && b_hs) begin
            if (wr_cnt_q == '0) err_d = 1'b1;
            else                wr_cnt_d = wr_cnt_q - WrCntW'(1);
        end

        // A valid without a handshake means the interconnect stalled it.
        if (ar_hs)                   ar_presented_d = 1'b0;
        else if (mst_req_o.ar_valid) ar_presented_d = 1'b1;
        if (aw_hs)                   aw_presented_d = 1'b0;
        else if (mst_req_o.aw_valid) aw_presented_d = 1'b1;
    end

    // Drain is judged on post-update values so ack follows the last response by one cycle.
    assign drained_d = (rd_cnt_d == '0) & (wr_cnt_d == '0) & ~ar_presented_d & ~aw_presented_d;

    // Quiesce FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (quiesce_req_i) state_d = DRAIN;
            DRAIN: begin
                if (!quiesce_req_i)  state_d = IDLE;
                else if (drained_d)  state_d = HALTED;
            end
            HALTED:  if (!quiesce_req_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, counters and flags register.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values regardless of order.
        if (rst_i) begin
            state_q        <= IDLE;
            rd_cnt_q       <= '0;
            wr_cnt_q       <= '0;
            ar_presented_q <= 1'b0;
            aw_presented_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            rd_cnt_q       <= rd_cnt_d;
            wr_cnt_q       <= wr_cnt_d;
            ar_presented_q <= ar_presented_d;
            aw_presented_q <= aw_presented_d;
            err_q          <= err_d;
        end
    end

    assign quiesce_ack_o    = (state_q == HALTED);
    assign busy_o           = (rd_cnt_q != '0) | (wr_cnt_q != '0);
    assign rd_outstanding_o = rd_cnt_q;
    assign wr_outstanding_o = wr_cnt_q;
    assign err_o            = err_q;
endmodule

// File: tb/tb_axi_outstanding_gate.sv
// Scoreboarded bench for axi_outstanding_gate (read limit 3, write limit 2).
module tb_axi_outstanding_gate;
    import axi_gate_pkg::*;

    logic        clk;
    logic        rst;
    req_t        slv_req;
    resp_t       slv_resp;
    req_t        mst_req;
    resp_t       mst_resp;
    logic        quiesce_req;
    logic        ack;
    logic        busy;
    logic [1:0]  rd_out;
    logic [1:0]  wr_out;
    logic        err;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] exp_ar_q[$];
    logic [63:0] exp_aw_q[$];
    logic [63:0] exp_w_q[$];
    logic [63:0] exp_r_q[$];
    logic [63:0] exp_b_q[$];

    axi_outstanding_gate #(
        .AxiIdWidth  (4),
        .MaxReadTxns (3),
        .MaxWriteTxns(2)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .slv_req_i       (slv_req),
        .slv_resp_o      (slv_resp),
        .mst_req_o       (mst_req),
        .mst_resp_i      (mst_resp),
        .quiesce_req_i   (quiesce_req),
        .quiesce_ack_o   (ack),
        .busy_o          (busy),
        .rd_outstanding_o(rd_out),
        .wr_outstanding_o(wr_out),
        .err_o           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ar_present(input logic [3:0] id);
        slv_req.ar.id    = id;
        slv_req.ar.addr  = {28'h0000100, id};
        slv_req.ar_valid = 1'b1;
        exp_ar_q.push_back(64'(id));
    endtask

    task automatic aw_present(input logic [3:0] id);
        slv_req.aw.id    = id;
        slv_req.aw.addr  = {28'h0000200, id};
        slv_req.aw_valid = 1'b1;
        exp_aw_q.push_back(64'(id));
    endtask

    task automatic w_beat(input logic [63:0] data);
        slv_req.w.data  = data;
        slv_req.w.last  = 1'b1;
        slv_req.w_valid = 1'b1;
        exp_w_q.push_back(data);
    endtask

    task automatic r_beat(input logic [63:0] data, input logic last);
        mst_resp.r.data  = data;
        mst_resp.r.last  = last;
        mst_resp.r_valid = 1'b1;
        exp_r_q.push_back(data);
    endtask

    task automatic b_beat(input logic [3:0] id);
        mst_resp.b.id    = id;
        mst_resp.b_valid = 1'b1;
        exp_b_q.push_back(64'(id));
    endtask

    // Every handshake seen on the far side must match the next expected item.
    always @(negedge clk) begin
        if (mst_req.ar_valid && mst_resp.ar_ready) begin
            if (exp_ar_q.size() == 0) check("ar_unexpected", 64'd1, 64'd0);
            else check("ar_id", 64'(mst_req.ar.id), exp_ar_q.pop_front());
        end
        if (mst_req.aw_valid && mst_resp.aw_ready) begin
            if (exp_aw_q.size() == 0) check("aw_unexpected", 64'd1, 64'd0);
            else check("aw_id", 64'(mst_req.aw.id), exp_aw_q.pop_front());
        end
        if (mst_req.w_valid && mst_resp.w_ready) begin
            if (exp_w_q.size() == 0) check("w_unexpected", 64'd1, 64'd0);
            else check("w_data", mst_req.w.data, exp_w_q.pop_front());
        end
        if (slv_resp.r_valid && slv_req.r_ready) begin
            if (exp_r_q.size() == 0) check("r_unexpected", 64'd1, 64'd0);
            else check("r_data", slv_resp.r.data, exp_r_q.pop_front());
        end
        if (slv_resp.b_valid && slv_req.b_ready) begin
            if (exp_b_q.size() == 0) check("b_unexpected", 64'd1, 64'd0);
            else check("b_id", 64'(slv_resp.b.id), exp_b_q.pop_front());
        end
    end

    initial begin
        slv_req     = '0;
        mst_resp    = '0;
        quiesce_req = 1'b0;
        rst         = 1'b1;

        // Handshakes must be shut while reset is asserted.
        slv_req.ar_valid  = 1'b1;
        slv_req.aw_valid  = 1'b1;
        mst_resp.ar_ready = 1'b1;
        mst_resp.aw_ready = 1'b1;
        #2;
        check("rst_mst_ar_valid", 64'(mst_req.ar_valid), 64'd0);
        check("rst_slv_ar_ready", 64'(slv_resp.ar_ready), 64'd0);
        check("rst_mst_aw_valid", 64'(mst_req.aw_valid), 64'd0);
        tick();
        tick();
        slv_req.ar_valid = 1'b0;
        slv_req.aw_valid = 1'b0;
        check("rst_rd_cnt", 64'(rd_out), 64'd0);
        check("rst_wr_cnt", 64'(wr_out), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        rst               = 1'b0;
        mst_resp.w_ready  = 1'b1;
        slv_req.r_ready   = 1'b1;
        slv_req.b_ready   = 1'b1;

        // Read cap: three accepted, fourth stalled until one R-last retires.
        ar_present(4'd1); tick();
        ar_present(4'd2); tick();
        ar_present(4'd3); tick();
        check("cap_rd_cnt3", 64'(rd_out), 64'd3);
        check("cap_busy", 64'(busy), 64'd1);
        ar_present(4'd4); #1;
        check("cap_slv_ar_ready", 64'(slv_resp.ar_ready), 64'd0);
        check("cap_mst_ar_valid", 64'(mst_req.ar_valid), 64'd0);
        tick();
        check("cap_rd_hold", 64'(rd_out), 64'd3);
        r_beat(64'hA1, 1'b1); #1;
        check("cap_still_stalled", 64'(slv_resp.ar_ready), 64'd0);
        tick();
        mst_resp.r_valid = 1'b0; #1;
        check("cap_rd_dropped", 64'(rd_out), 64'd2);
        check("cap_release_ready", 64'(slv_resp.ar_ready), 64'd1);
        tick();
        slv_req.ar_valid = 1'b0;
        check("cap_rd_refill", 64'(rd_out), 64'd3);

        // Simultaneous AR and R-last at count 1, then a 4-beat burst.
        r_beat(64'hA2, 1'b1); tick();
        r_beat(64'hA3, 1'b1); tick();
        mst_resp.r_valid = 1'b0;
        check("simul_pre", 64'(rd_out), 64'd1);
        ar_present(4'd5);
        r_beat(64'hA4, 1'b1);
        tick();
        slv_req.ar_valid = 1'b0;
        mst_resp.r_valid = 1'b0;
        check("simul_cnt", 64'(rd_out), 64'd1);
        for (int i = 0; i < 4; i++) begin
            r_beat(64'hB0 + 64'(i), (i == 3));
            tick();
            check("burst_cnt", 64'(rd_out), (i == 3) ? 64'd0 : 64'd1);
        end
        mst_resp.r_valid = 1'b0;

        // Quiesce drain with one read and two writes outstanding.
        ar_present(4'd6); tick();
        slv_req.ar_valid = 1'b0;
        aw_present(4'd1); tick();
        aw_present(4'd2); tick();
        slv_req.aw_valid = 1'b0;
        check("drain_wr_cnt", 64'(wr_out), 64'd2);
        check("drain_rd_cnt", 64'(rd_out), 64'd1);
        aw_present(4'd3); #1;
        check("wcap_slv_aw_ready", 64'(slv_resp.aw_ready), 64'd0);
        quiesce_req = 1'b1;
        tick();
        check("drain_ack_low", 64'(ack), 64'd0);
        ar_present(4'd7);
        w_beat(64'hC1); #1;
        check("drain_ar_blocked", 64'(mst_req.ar_valid), 64'd0);
        check("drain_aw_blocked", 64'(mst_req.aw_valid), 64'd0);
        check("drain_w_passes", 64'(mst_req.w_valid), 64'd1);
        tick();
        slv_req.w_valid = 1'b0;
        r_beat(64'hA5, 1'b1); tick();
        mst_resp.r_valid = 1'b0;
        check("drain_ack_after_r", 64'(ack), 64'd0);
        b_beat(4'd1); tick();
        check("drain_ack_after_b1", 64'(ack), 64'd0);
        b_beat(4'd2); tick();
        mst_resp.b_valid = 1'b0;
        check("drain_ack_rise", 64'(ack), 64'd1);
        check("drain_idle_busy", 64'(busy), 64'd0);
        tick();
        check("halted_ack_hold", 64'(ack), 64'd1);
        check("halted_ar_blocked", 64'(mst_req.ar_valid), 64'd0);
        quiesce_req = 1'b0; #1;
        check("release_same_cycle_blocked", 64'(mst_req.ar_valid), 64'd0);
        tick();
        check("release_ack_fall", 64'(ack), 64'd0);
        check("release_ar_issue", 64'(mst_req.ar_valid), 64'd1);
        check("release_aw_issue", 64'(mst_req.aw_valid), 64'd1);
        tick();
        slv_req.ar_valid = 1'b0;
        slv_req.aw_valid = 1'b0;
        check("release_rd_cnt", 64'(rd_out), 64'd1);
        check("release_wr_cnt", 64'(wr_out), 64'd1);

        // Valid stability: a stalled AR keeps valid through quiesce and is drained.
        mst_resp.ar_ready = 1'b0;
        ar_present(4'd8); tick();
        quiesce_req = 1'b1; tick();
        check("stable_ar_valid1", 64'(mst_req.ar_valid), 64'd1);
        tick();
        check("stable_ar_valid2", 64'(mst_req.ar_valid), 64'd1);
        check("stable_ack_low", 64'(ack), 64'd0);
        mst_resp.ar_ready = 1'b1;
        tick();
        slv_req.ar_valid = 1'b0;
        check("stable_rd_cnt", 64'(rd_out), 64'd2);
        check("stable_ack_low2", 64'(ack), 64'd0);
        r_beat(64'hA6, 1'b1);
        b_beat(4'd3);
        tick();
        mst_resp.b_valid = 1'b0;
        check("stable_ack_partial", 64'(ack), 64'd0);
        r_beat(64'hA7, 1'b1); tick();
        mst_resp.r_valid = 1'b0;
        check("stable_ack_rise", 64'(ack), 64'd1);
        quiesce_req = 1'b0; tick();
        check("stable_ack_fall", 64'(ack), 64'd0);

        // Abort: dropping the request in DRAIN resumes issue.
        ar_present(4'd9); tick();
        slv_req.ar_valid = 1'b0;
        quiesce_req = 1'b1; tick();
        ar_present(4'd10); #1;
        check("abort_blocked", 64'(mst_req.ar_valid), 64'd0);
        quiesce_req = 1'b0; tick();
        check("abort_resumed", 64'(mst_req.ar_valid), 64'd1);
        tick();
        slv_req.ar_valid = 1'b0;
        check("abort_rd_cnt", 64'(rd_out), 64'd2);
        check("abort_ack_low", 64'(ack), 64'd0);
        r_beat(64'hA8, 1'b1); tick();
        r_beat(64'hA9, 1'b1); tick();
        mst_resp.r_valid = 1'b0;

        // Underflow: a B with nothing outstanding.
        check("err_before", 64'(err), 64'd0);
        b_beat(4'd4); tick();
        mst_resp.b_valid = 1'b0;
        check("err_set", 64'(err), 64'd1);
        check("err_wr_hold0", 64'(wr_out), 64'd0);
        tick(); tick();
        check("err_sticky", 64'(err), 64'd1);

        // Reset mid-burst with counts 3/2 while draining.
        ar_present(4'd11); tick();
        ar_present(4'd12); tick();
        ar_present(4'd13); tick();
        slv_req.ar_valid = 1'b0;
        aw_present(4'd4); tick();
        aw_present(4'd5); tick();
        slv_req.aw_valid = 1'b0;
        check("mid_rd_cnt", 64'(rd_out), 64'd3);
        check("mid_wr_cnt", 64'(wr_out), 64'd2);
        quiesce_req = 1'b1; tick();
        rst = 1'b1;
        quiesce_req = 1'b0;
        tick();
        check("mid_rst_rd", 64'(rd_out), 64'd0);
        check("mid_rst_wr", 64'(wr_out), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_ack", 64'(ack), 64'd0);
        check("mid_rst_err", 64'(err), 64'd0);
        rst = 1'b0;
        ar_present(4'd14); #1;
        check("mid_rst_idle_issue", 64'(mst_req.ar_valid), 64'd1);
        tick();
        slv_req.ar_valid = 1'b0;
        check("mid_rst_recount", 64'(rd_out), 64'd1);

        tick();
        check("ar_q_empty", 64'(exp_ar_q.size()), 64'd0);
        check("aw_q_empty", 64'(exp_aw_q.size()), 64'd0);
        check("w_q_empty", 64'(exp_w_q.size()), 64'd0);
        check("r_q_empty", 64'(exp_r_q.size()), 64'd0);
        check("b_q_empty", 64'(exp_b_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
